otter_hazard_ctrl: RTL and testbench
====================================

// Module: otter_hazard_ctrl
// PURPOSE
// - Pipeline sequencer for the 5-stage OTTER: drives PC/stage-register enables and flushes, and selects ALU operand forwarding.
// - Inputs are the per-stage decoded fields: rs/rd addresses, used flags, regWrite and memRead2.
// - Sits beside the IF/ID/EX/MEM/WB registers. Holds the pipeline while the serial programmer owns memory.
// - Keeps saturating stall and flush event counters for bring-up.
// PARAMETERS
// FLUSH_DEPTH  1   extra cycles after a taken branch/jump spent squashing in-flight fetches (synchronous IMEM); range 0..3
// CNT_W        32  width of the STALL_CNT and FLUSH_CNT performance counters
// PORTS
// CLK          in   1      system clock, all state on posedge
// RESET_N      in   1      asynchronous, active-low reset
// PROG_HOLD    in   1      programmer mcu_reset/ram_we active; memory owned by programmer
// ID_RS1       in   5      decode-stage rs1 address
// ID_RS2       in   5      decode-stage rs2 address
// ID_RS1_USED  in   1      decode-stage rs1 is read
// ID_RS2_USED  in   1      decode-stage rs2 is read
// EX_RD        in   5      execute-stage rd
// EX_REGWRITE  in   1      execute-stage instruction writes rd
// EX_MEMREAD   in   1      execute-stage instruction is a load
// EX_BR_TAKEN  in   1      execute stage resolved a taken branch, JAL, JALR or trap (pc_sel != next_pc)
// MEM_RD       in   5      memory-stage rd
// MEM_REGWRITE in   1      memory-stage instruction writes rd
// WB_RD        in   5      writeback-stage rd
// WB_REGWRITE  in   1      writeback-stage instruction writes rd
// PC_WE        out  1      PC load enable
// IF_ID_EN     out  1      IF/ID register enable
// IF_ID_FLUSH  out  1      load NOP into IF/ID
// ID_EX_FLUSH  out  1      load NOP (bubble) into ID/EX
// EX_MEM_EN    out  1      EX/MEM and MEM/WB enable; 0 only in HOLD
// FWD_A_SEL    out  2      rs1 operand source: 0 = RF, 1 = MEM-stage ALU result, 2 = WB data
// FWD_B_SEL    out  2      rs2 operand source: same encoding as FWD_A_SEL
// STALL_CNT    out  CNT_W  number of load-use stall cycles, saturating
// FLUSH_CNT    out  CNT_W  number of taken-redirect events, saturating
// BEHAVIOUR
// - FSM states: RUN, LOAD_STALL, FLUSH, HOLD. 2-bit down-counter flush_cnt.
// - Control outputs are Mealy: decoded from state plus current inputs, effective at the same posedge.
// - Reset (RESET_N=0):
//   - state=HOLD, counters=0, flush_cnt=0.
//   - Outputs: PC_WE=0, IF_ID_EN=0, EX_MEM_EN=0, IF_ID_FLUSH=1, ID_EX_FLUSH=1, FWD_*=0.
//   - First edge after release: HOLD->RUN unless PROG_HOLD=1.
// - Priority every cycle: PROG_HOLD > EX_BR_TAKEN > load-use > normal.
// - Load-use hazard: EX_MEMREAD & EX_REGWRITE & EX_RD!=0 & ((ID_RS1_USED & ID_RS1==EX_RD) | (ID_RS2_USED & ID_RS2==EX_RD)).
// - HOLD:
//   - All enables 0, both flushes 1.
//   - Stays while PROG_HOLD=1, then ->RUN.
//   - Entered from any state on PROG_HOLD=1; flush_cnt is cleared.
// - RUN, taken redirect:
//   - PC_WE=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, FLUSH_CNT++.
//   - If FLUSH_DEPTH>0: ->FLUSH with flush_cnt=FLUSH_DEPTH. Else stay RUN.
// - RUN, load-use:
//   - PC_WE=0, IF_ID_EN=0, ID_EX_FLUSH=1, STALL_CNT++.
//   - ->LOAD_STALL.
// - RUN, otherwise: PC_WE=1, IF_ID_EN=1, no flush.
// - LOAD_STALL:
//   - Exactly one cycle. Outputs as RUN-normal (the load is now in MEM; its data is forwarded from WB next cycle). ->RUN.
//   - EX_BR_TAKEN here is handled exactly as in RUN.
// - FLUSH:
//   - PC_WE=1, IF_ID_EN=1, IF_ID_FLUSH=1.
//   - flush_cnt decrements; ->RUN when flush_cnt reaches 1.
//   - A new EX_BR_TAKEN reloads flush_cnt=FLUSH_DEPTH and counts as a new redirect.
// - Forwarding, evaluated per operand:
//   - rsX==0 or !used -> 0.
//   - Else MEM_REGWRITE & MEM_RD==rsX -> 1.
//   - Else WB_REGWRITE & WB_RD==rsX -> 2.
//   - Else 0. MEM takes precedence over WB.
// - Counters: +1 per event, hold at 2^CNT_W-1. Cleared only by reset.
// - Reset asserted mid-FLUSH or mid-LOAD_STALL: immediate return to the reset output values.
// STRUCTURE
// - otter_pkg: hz_state_t enum (RUN, LOAD_STALL, FLUSH, HOLD), fwd_sel_t (FWD_RF=0, FWD_MEM=1, FWD_WB=2), opcode_t (shared with the stage-register instr_t).
// - Sub-module otter_fwd_unit: combinational, one per operand (rs, used, MEM/WB rd+regWrite -> fwd_sel_t); instantiated twice.
// - FSM, flush counter and performance counters stay in this module.
// TESTING
// - Reset release with PROG_HOLD=0: first edge HOLD->RUN; next cycle PC_WE=1, IF_ID_EN=1, counters=0.
// - Load-use stall:
//   - Stimulus: EX lw x5 (EX_MEMREAD=1, EX_RD=5), ID add x6,x5,x1.
//   - Response: PC_WE=0, IF_ID_EN=0, ID_EX_FLUSH=1 for 1 cycle; next cycle FWD_A_SEL=2; STALL_CNT=1.
// - Taken branch with FLUSH_DEPTH=1:
//   - Stimulus: EX_BR_TAKEN=1.
//   - Response: both flushes 1 that cycle; IF_ID_FLUSH=1 one more cycle; then RUN; FLUSH_CNT=1.
// - Simultaneous events:
//   - Stimulus: EX_BR_TAKEN=1 together with a load-use match.
//   - Response: redirect wins; STALL_CNT unchanged; PC_WE=1.
// - Forwarding priority:
//   - Stimulus: MEM_RD=WB_RD=7, both regWrite=1, ID_RS2=7.
//   - Response: FWD_B_SEL=1. With ID_RS1=0 and a match: FWD_A_SEL=0.
// - PROG_HOLD during FLUSH: next cycle all enables 0; after deassert, RUN with flush_cnt=0. Separately, CNT_W=4 with 20 stalls: STALL_CNT=15.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared types for the OTTER pipeline: hazard-controller states, forwarding
// selects and the RV32I opcode / instruction layout used by the stage registers.
package otter_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    HOLD       = 2'd3
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYS    = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    opcode_t    opcode;
  } instr_t;

endpackage

// File: rtl/otter_fwd_unit.sv
// Per-operand forwarding select: the youngest in-flight writer of rs wins,
// x0 and unread operands always come from the register file.
module otter_fwd_unit
  import otter_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       used,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_RF;
    if (used && rs != '0) begin
      if (mem_regwrite && mem_rd == rs)
        sel = FWD_MEM;
      else if (wb_regwrite && wb_rd == rs)
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER 5-stage pipeline sequencer: stage enables/flushes, operand forwarding
// selects and saturating stall/redirect counters for bring-up.
module otter_hazard_ctrl
  import otter_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             PROG_HOLD,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_RS1_USED,
  input  logic             ID_RS2_USED,
  input  logic [4:0]       EX_RD,
  input  logic             EX_REGWRITE,
  input  logic             EX_MEMREAD,
  input  logic             EX_BR_TAKEN,
  input  logic [4:0]       MEM_RD,
  input  logic             MEM_REGWRITE,
  input  logic [4:0]       WB_RD,
  input  logic             WB_REGWRITE,
  output logic             PC_WE,
  output logic             IF_ID_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             EX_MEM_EN,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  hz_state_t  state;
  logic [1:0] flush_cnt;
  logic       hold_now;
  logic       load_use;
  logic       redirect;
  logic       stall;
  fwd_sel_t   fwd_a;
  fwd_sel_t   fwd_b;

  otter_fwd_unit u_fwd_a (
    .rs           (ID_RS1),
    .used         (ID_RS1_USED),
    .mem_rd       (MEM_RD),
    .mem_regwrite (MEM_REGWRITE),
    .wb_rd        (WB_RD),
    .wb_regwrite  (WB_REGWRITE),
    .sel          (fwd_a)
  );

  otter_fwd_unit u_fwd_b (
    .rs           (ID_RS2),
    .used         (ID_RS2_USED),
    .mem_rd       (MEM_RD),
    .mem_regwrite (MEM_REGWRITE),
    .wb_rd        (WB_RD),
    .wb_regwrite  (WB_REGWRITE),
    .sel          (fwd_b)
  );

  // Forwarding is forced to the register file while the pipeline is frozen,
  // which also yields the reset values since reset forces HOLD asynchronously.
  assign FWD_A_SEL = (state == HOLD) ? FWD_RF : fwd_a;
  assign FWD_B_SEL = (state == HOLD) ? FWD_RF : fwd_b;

  always_comb begin
    hold_now = PROG_HOLD || (state == HOLD);
    load_use = EX_MEMREAD && EX_REGWRITE && (EX_RD != '0) &&
               ((ID_RS1_USED && ID_RS1 == EX_RD) || (ID_RS2_USED && ID_RS2 == EX_RD));
    redirect = !hold_now && EX_BR_TAKEN;
    stall    = !hold_now && !redirect && (state == RUN) && load_use;
  end

  always_comb begin
    PC_WE       = 1'b1;
    IF_ID_EN    = 1'b1;
    IF_ID_FLUSH = 1'b0;
    ID_EX_FLUSH = 1'b0;
    EX_MEM_EN   = 1'b1;
    if (hold_now) begin
      PC_WE       = 1'b0;
      IF_ID_EN    = 1'b0;
      EX_MEM_EN   = 1'b0;
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (redirect) begin
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (state == FLUSH) begin
      IF_ID_FLUSH = 1'b1;
    end else if (stall) begin
      PC_WE       = 1'b0;
      IF_ID_EN    = 1'b0;
      ID_EX_FLUSH = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= HOLD;
      flush_cnt <= '0;
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else if (PROG_HOLD) begin
      state     <= HOLD;
      flush_cnt <= '0;
    end else if (state == HOLD) begin
      state <= RUN;
    end else if (redirect) begin
      if (FLUSH_CNT != '1)
        FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
      if (FLUSH_DEPTH > 0) begin
        state     <= FLUSH;
        flush_cnt <= 2'(FLUSH_DEPTH);
      end else begin
        state <= RUN;
      end
    end else if (state == FLUSH) begin
      if (flush_cnt <= 2'd1) begin
        state     <= RUN;
        flush_cnt <= '0;
      end else begin
        flush_cnt <= flush_cnt - 2'd1;
      end
    end else if (stall) begin
      state <= LOAD_STALL;
      if (STALL_CNT != '1)
        STALL_CNT <= STALL_CNT + CNT_W'(1);
    end else begin
      state <= RUN;
    end
  end

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Bench for otter_hazard_ctrl: two instances (default and FLUSH_DEPTH=2/CNT_W=4)
// checked against a cycle-level behavioural model of the sequencing rules.
module tb_otter_hazard_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET_N, PROG_HOLD;
  logic [4:0] ID_RS1, ID_RS2, EX_RD, MEM_RD, WB_RD;
  logic       ID_RS1_USED, ID_RS2_USED, EX_REGWRITE, EX_MEMREAD, EX_BR_TAKEN;
  logic       MEM_REGWRITE, WB_REGWRITE;

  logic        pc_we [2];
  logic        if_id_en [2];
  logic        if_id_flush [2];
  logic        id_ex_flush [2];
  logic        ex_mem_en [2];
  logic [1:0]  fwd_a [2];
  logic [1:0]  fwd_b [2];
  logic [31:0] stall0, flush0;
  logic [3:0]  stall1, flush1;

  otter_hazard_ctrl #(.FLUSH_DEPTH(1), .CNT_W(32)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .PROG_HOLD(PROG_HOLD),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .EX_RD(EX_RD), .EX_REGWRITE(EX_REGWRITE), .EX_MEMREAD(EX_MEMREAD), .EX_BR_TAKEN(EX_BR_TAKEN),
    .MEM_RD(MEM_RD), .MEM_REGWRITE(MEM_REGWRITE), .WB_RD(WB_RD), .WB_REGWRITE(WB_REGWRITE),
    .PC_WE(pc_we[0]), .IF_ID_EN(if_id_en[0]), .IF_ID_FLUSH(if_id_flush[0]),
    .ID_EX_FLUSH(id_ex_flush[0]), .EX_MEM_EN(ex_mem_en[0]),
    .FWD_A_SEL(fwd_a[0]), .FWD_B_SEL(fwd_b[0]), .STALL_CNT(stall0), .FLUSH_CNT(flush0)
  );

  otter_hazard_ctrl #(.FLUSH_DEPTH(2), .CNT_W(4)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .PROG_HOLD(PROG_HOLD),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .EX_RD(EX_RD), .EX_REGWRITE(EX_REGWRITE), .EX_MEMREAD(EX_MEMREAD), .EX_BR_TAKEN(EX_BR_TAKEN),
    .MEM_RD(MEM_RD), .MEM_REGWRITE(MEM_REGWRITE), .WB_RD(WB_RD), .WB_REGWRITE(WB_REGWRITE),
    .PC_WE(pc_we[1]), .IF_ID_EN(if_id_en[1]), .IF_ID_FLUSH(if_id_flush[1]),
    .ID_EX_FLUSH(id_ex_flush[1]), .EX_MEM_EN(ex_mem_en[1]),
    .FWD_A_SEL(fwd_a[1]), .FWD_B_SEL(fwd_b[1]), .STALL_CNT(stall1), .FLUSH_CNT(flush1)
  );

  // Model: frozen flag, "just stalled" flag, remaining squash cycles, event totals.
  bit     m_hold [2];
  bit     m_stalled [2];
  int     m_left [2];
  longint m_stall [2];
  longint m_flush [2];
  int     depth [2] = '{1, 2};
  longint cap [2]   = '{64'hFFFF_FFFF, 64'd15};

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit load_use();
    return EX_MEMREAD && EX_REGWRITE && EX_RD != 0 &&
           ((ID_RS1_USED && ID_RS1 == EX_RD) || (ID_RS2_USED && ID_RS2 == EX_RD));
  endfunction

  function automatic int exp_fwd(bit frozen, logic [4:0] rs, logic used);
    if (frozen || rs == 0 || !used) return 0;
    if (MEM_REGWRITE && MEM_RD == rs) return 1;
    if (WB_REGWRITE && WB_RD == rs) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hold[i] = 1; m_stalled[i] = 0; m_left[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (PROG_HOLD) begin
        m_hold[i] = 1; m_left[i] = 0; m_stalled[i] = 0;
      end else if (m_hold[i]) begin
        m_hold[i] = 0;
      end else if (EX_BR_TAKEN) begin
        if (m_flush[i] < cap[i]) m_flush[i]++;
        m_left[i] = depth[i]; m_stalled[i] = 0;
      end else if (m_left[i] > 0) begin
        m_left[i]--;
      end else if (!m_stalled[i] && load_use()) begin
        if (m_stall[i] < cap[i]) m_stall[i]++;
        m_stalled[i] = 1;
      end else begin
        m_stalled[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    bit e_pc, e_en, e_iff, e_idf, e_ex;
    logic [31:0] obs_st, obs_fl;
    for (int i = 0; i < 2; i++) begin
      if (m_hold[i] || PROG_HOLD)              {e_pc, e_en, e_iff, e_idf, e_ex} = 5'b00110;
      else if (EX_BR_TAKEN)                    {e_pc, e_en, e_iff, e_idf, e_ex} = 5'b11111;
      else if (m_left[i] > 0)                  {e_pc, e_en, e_iff, e_idf, e_ex} = 5'b11101;
      else if (!m_stalled[i] && load_use())    {e_pc, e_en, e_iff, e_idf, e_ex} = 5'b00011;
      else                                     {e_pc, e_en, e_iff, e_idf, e_ex} = 5'b11001;
      obs_st = (i == 0) ? stall0 : {28'd0, stall1};
      obs_fl = (i == 0) ? flush0 : {28'd0, flush1};
      chk($sformatf("i%0d pc_we", i), 32'(pc_we[i]), 32'(e_pc));
      chk($sformatf("i%0d if_id_en", i), 32'(if_id_en[i]), 32'(e_en));
      chk($sformatf("i%0d if_id_flush", i), 32'(if_id_flush[i]), 32'(e_iff));
      chk($sformatf("i%0d id_ex_flush", i), 32'(id_ex_flush[i]), 32'(e_idf));
      chk($sformatf("i%0d ex_mem_en", i), 32'(ex_mem_en[i]), 32'(e_ex));
      chk($sformatf("i%0d fwd_a", i), 32'(fwd_a[i]), 32'(exp_fwd(m_hold[i], ID_RS1, ID_RS1_USED)));
      chk($sformatf("i%0d fwd_b", i), 32'(fwd_b[i]), 32'(exp_fwd(m_hold[i], ID_RS2, ID_RS2_USED)));
      chk($sformatf("i%0d stall_cnt", i), obs_st, m_stall[i][31:0]);
      chk($sformatf("i%0d flush_cnt", i), obs_fl, m_flush[i][31:0]);
    end
  endtask

  // Entered and left at a negedge: inputs are already set for this cycle.
  task automatic cycle();
    #1 check_all();
    @(posedge CLK);
    if (RESET_N) model_edge();
    @(negedge CLK);
  endtask

  task automatic clr();
    PROG_HOLD = 0; EX_BR_TAKEN = 0; EX_MEMREAD = 0; EX_REGWRITE = 0; EX_RD = 0;
    ID_RS1 = 0; ID_RS2 = 0; ID_RS1_USED = 0; ID_RS2_USED = 0;
    MEM_RD = 0; MEM_REGWRITE = 0; WB_RD = 0; WB_REGWRITE = 0;
  endtask

  task automatic set_load_use();
    clr();
    EX_MEMREAD = 1; EX_REGWRITE = 1; EX_RD = 5;
    ID_RS1 = 5; ID_RS1_USED = 1; ID_RS2 = 1; ID_RS2_USED = 1;
  endtask

  initial begin
    RESET_N = 0;
    clr();
    model_reset();
    @(negedge CLK);
    ID_RS1 = 3; ID_RS1_USED = 1; MEM_RD = 3; MEM_REGWRITE = 1;
    cycle();                                    // reset values, fwd forced to RF
    clr();
    RESET_N = 1;
    cycle();                                    // still HOLD, first edge -> RUN
    #1 chk("run pc_we", 32'(pc_we[0]), 32'd1);
    chk("run stall0", stall0, 32'd0);
    cycle();

    set_load_use();                             // lw x5 in EX, add x6,x5,x1 in ID
    #1 chk("lu pc_we", 32'(pc_we[0]), 32'd0);
    chk("lu if_id_en", 32'(if_id_en[0]), 32'd0);
    chk("lu id_ex_flush", 32'(id_ex_flush[0]), 32'd1);
    cycle();
    clr();
    ID_RS1 = 5; ID_RS1_USED = 1; WB_RD = 5; WB_REGWRITE = 1;
    #1 chk("lu fwd_a", 32'(fwd_a[0]), 32'd2);
    chk("lu stall0", stall0, 32'd1);
    cycle();
    clr();
    cycle();

    EX_BR_TAKEN = 1;                            // taken redirect
    #1 chk("br if_id_flush", 32'(if_id_flush[0]), 32'd1);
    chk("br id_ex_flush", 32'(id_ex_flush[0]), 32'd1);
    cycle();
    clr();
    #1 chk("br squash", 32'(if_id_flush[0]), 32'd1);
    chk("br squash idex", 32'(id_ex_flush[0]), 32'd0);
    cycle();
    #1 chk("br back run", 32'(if_id_flush[0]), 32'd0);
    chk("br flush0", flush0, 32'd1);
    cycle();
    repeat (3) cycle();

    set_load_use();                             // redirect beats load-use
    EX_BR_TAKEN = 1;
    #1 chk("sim pc_we", 32'(pc_we[0]), 32'd1);
    cycle();
    clr();
    #1 chk("sim stall0", stall0, 32'd1);
    cycle();
    repeat (3) cycle();

    MEM_RD = 7; WB_RD = 7; MEM_REGWRITE = 1; WB_REGWRITE = 1;
    ID_RS2 = 7; ID_RS2_USED = 1; ID_RS1 = 0; ID_RS1_USED = 1;
    #1 chk("fwd mem>wb", 32'(fwd_b[0]), 32'd1);
    chk("fwd x0", 32'(fwd_a[0]), 32'd0);
    cycle();
    clr();

    EX_BR_TAKEN = 1;                            // PROG_HOLD while squashing
    cycle();
    clr();
    PROG_HOLD = 1;
    cycle();
    #1 chk("ph pc_we", 32'(pc_we[0]), 32'd0);
    chk("ph ex_mem_en", 32'(ex_mem_en[0]), 32'd0);
    cycle();
    PROG_HOLD = 0;
    cycle();
    #1 chk("ph run no squash", 32'(if_id_flush[0]), 32'd0);
    chk("ph run pc_we", 32'(pc_we[0]), 32'd1);
    cycle();

    repeat (20) begin                           // saturate the 4-bit counter
      set_load_use();
      cycle();
      clr();
      cycle();
    end
    #1 chk("sat stall1", {28'd0, stall1}, 32'd15);

    set_load_use();                             // async reset mid LOAD_STALL
    cycle();
    RESET_N = 0;
    model_reset();
    #1 chk("rst stall0", stall0, 32'd0);
    cycle();
    RESET_N = 1;
    clr();
    cycle();

    repeat (2000) begin
      PROG_HOLD    = ($urandom_range(15) == 0);
      EX_BR_TAKEN  = ($urandom_range(5) == 0);
      EX_MEMREAD   = ($urandom_range(2) == 0);
      EX_REGWRITE  = 1'($urandom);
      EX_RD        = 5'($urandom_range(7));
      ID_RS1       = 5'($urandom_range(7));
      ID_RS2       = 5'($urandom_range(7));
      ID_RS1_USED  = 1'($urandom);
      ID_RS2_USED  = 1'($urandom);
      MEM_RD       = 5'($urandom_range(7));
      MEM_REGWRITE = 1'($urandom);
      WB_RD        = 5'($urandom_range(7));
      WB_REGWRITE  = 1'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
